// File: rtl/xbar_route_sequencer.sv
// Steps cyclically through a host-programmed table of crossbar routes, each held
// for its own dwell time, and drives the crossbar's one-hot command and enable.
module xbar_route_sequencer #(
   parameter int NUM_INPUT_DATA  = 16,
   parameter int NUM_OUTPUT_DATA = 8,
   parameter int SRC_W           = 4,
   parameter int TABLE_DEPTH     = 8,
   parameter int DWELL_W         = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        cfg_wr_en,
   input  logic [$clog2(TABLE_DEPTH)-1:0]              cfg_wr_addr,
   input  logic [NUM_OUTPUT_DATA*(SRC_W+1)-1:0]        cfg_wr_route,
   input  logic [DWELL_W-1:0]                          cfg_wr_dwell,
   input  logic [$clog2(TABLE_DEPTH):0]                cfg_num_entries,
   input  logic                                        start,
   input  logic                                        stop,
   output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]   o_cmd,
   output logic                                        o_en,
   output logic [$clog2(TABLE_DEPTH)-1:0]              o_entry_idx,
   output logic                                        o_switch,
   output logic                                        o_busy,
   output logic                                        o_cfg_err
);

   localparam int AW = $clog2(TABLE_DEPTH);
   localparam int RW = NUM_OUTPUT_DATA * (SRC_W + 1);
   localparam int CW = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cmd_p0, cmd_nxt;
   logic                vld_p0, vld_nxt;
   logic [AW-1:0]       idx_p0, idx_nxt;
   logic                sw_p0, sw_nxt;
   logic                err_p0, err_nxt;
   logic [DWELL_W-1:0]  cnt, cnt_nxt;
   logic [AW:0]         n_lat, n_nxt;

   logic [RW-1:0]       route_mem [TABLE_DEPTH];
   logic [DWELL_W-1:0]  dwell_mem [TABLE_DEPTH];

   logic                wr_ok;
   logic [AW-1:0]       adv_idx;
   logic [AW-1:0]       rd_addr;
   logic [RW-1:0]       rd_route;
   logic [DWELL_W-1:0]  rd_dwell;

   function automatic logic [CW-1:0] decode(input logic [RW-1:0] r);
      logic [RW-1:0] f;
      logic [CW-1:0] c;
      c = '0;
      for (int d = 0; d < NUM_OUTPUT_DATA; d++) begin
         f = r >> (d * (SRC_W + 1));
         if (f[SRC_W])
            c = c | ({{(CW-1){1'b0}}, 1'b1} << (32'(f[SRC_W-1:0]) * NUM_OUTPUT_DATA + d));
      end
      return c;
   endfunction

   // The entry on the outputs is locked against writes while sequencing
   assign wr_ok   = cfg_wr_en && ((state == IDLE) || (cfg_wr_addr != idx_p0));
   assign adv_idx = (({1'b0, idx_p0} + (AW+1)'(1)) == n_lat) ? '0 : idx_p0 + AW'(1);
   assign rd_addr = (state == IDLE) ? '0 : adv_idx;

   // Write-first bypass so a same-edge write to the entry being applied is seen
   assign rd_route = (wr_ok && (cfg_wr_addr == rd_addr)) ? cfg_wr_route : route_mem[rd_addr];
   assign rd_dwell = (wr_ok && (cfg_wr_addr == rd_addr)) ? cfg_wr_dwell : dwell_mem[rd_addr];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         route_mem[cfg_wr_addr] <= cfg_wr_route;
         dwell_mem[cfg_wr_addr] <= cfg_wr_dwell;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd_p0;
      vld_nxt   = vld_p0;
      idx_nxt   = idx_p0;
      sw_nxt    = 1'b0;
      err_nxt   = 1'b0;
      cnt_nxt   = cnt;
      n_nxt     = n_lat;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               if ((cfg_num_entries != '0) && (cfg_num_entries <= (AW+1)'(TABLE_DEPTH))) begin
                  state_nxt = RUN;
                  n_nxt     = cfg_num_entries;
                  cmd_nxt   = decode(rd_route);
                  vld_nxt   = 1'b1;
                  idx_nxt   = '0;
                  sw_nxt    = 1'b1;
                  cnt_nxt   = rd_dwell;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RUN, STOPPING: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - DWELL_W'(1);
               if ((state == RUN) && stop)
                  state_nxt = STOPPING;
            end else if ((state == STOPPING) || stop) begin
               state_nxt = IDLE;
               cmd_nxt   = '0;
               vld_nxt   = 1'b0;
            end else begin
               idx_nxt = adv_idx;
               cnt_nxt = rd_dwell;
               cmd_nxt = decode(rd_route);
               sw_nxt  = 1'b1;
            end
            if (cfg_wr_en && !wr_ok)
               err_nxt = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cmd_p0 <= '0;
         vld_p0 <= 1'b0;
         idx_p0 <= '0;
         sw_p0  <= 1'b0;
         err_p0 <= 1'b0;
         cnt    <= '0;
         n_lat  <= '0;
      end else begin
         state  <= state_nxt;
         cmd_p0 <= cmd_nxt;
         vld_p0 <= vld_nxt;
         idx_p0 <= idx_nxt;
         sw_p0  <= sw_nxt;
         err_p0 <= err_nxt;
         cnt    <= cnt_nxt;
         n_lat  <= n_nxt;
      end
   end

   assign o_cmd       = cmd_p0;
   assign o_en        = vld_p0;
   assign o_entry_idx = idx_p0;
   assign o_switch    = sw_p0;
   assign o_busy      = (state != IDLE);
   assign o_cfg_err   = err_p0;

endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Directed bench for xbar_route_sequencer: hand-computed command words, dwell
// timing, graceful stop, write locking, rejected starts and asynchronous reset.
module tb_xbar_route_sequencer;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_wr_en = 1'b0;
   logic [2:0]    cfg_wr_addr = '0;
   logic [39:0]   cfg_wr_route = '0;
   logic [7:0]    cfg_wr_dwell = '0;
   logic [3:0]    cfg_num_entries = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [127:0]  o_cmd;
   logic          o_en;
   logic [2:0]    o_entry_idx;
   logic          o_switch;
   logic          o_busy;
   logic          o_cfg_err;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [127:0] CMD_IDENT = 128'h0000_0000_0000_0000_8040_2010_0804_0201;
   localparam logic [127:0] CMD_S15   = 128'hFF00_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [127:0] CMD_S8D0  = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
   localparam logic [127:0] CMD_S0D7  = 128'h0000_0000_0000_0000_0000_0000_0000_0080;
   localparam logic [39:0]  RT_ALL15  = 40'hFF_FFFF_FFFF;
   localparam logic [39:0]  RT_S8D0   = 40'h00_0000_0018;
   localparam logic [39:0]  RT_S0D7   = 40'h80_0000_0000;

   logic [39:0] rt_ident;

   xbar_route_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_wr_en       (cfg_wr_en),
      .cfg_wr_addr     (cfg_wr_addr),
      .cfg_wr_route    (cfg_wr_route),
      .cfg_wr_dwell    (cfg_wr_dwell),
      .cfg_num_entries (cfg_num_entries),
      .start           (start),
      .stop            (stop),
      .o_cmd           (o_cmd),
      .o_en            (o_en),
      .o_entry_idx     (o_entry_idx),
      .o_switch        (o_switch),
      .o_busy          (o_busy),
      .o_cfg_err       (o_cfg_err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [39:0] r, input logic [7:0] dw);
      cfg_wr_en    = 1'b1;
      cfg_wr_addr  = a;
      cfg_wr_route = r;
      cfg_wr_dwell = dw;
      tick();
      cfg_wr_en    = 1'b0;
   endtask

   initial begin
      rt_ident = '0;
      for (int d = 0; d < 8; d++)
         rt_ident = rt_ident | (40'(32'h10 + d) << (5 * d));

      // reset state
      #3 rst = 1'b0;
      #1;
      chk("rst_cmd", o_cmd, 128'd0);
      chk("rst_en", 128'(o_en), 128'd0);
      chk("rst_busy", 128'(o_busy), 128'd0);
      chk("rst_idx", 128'(o_entry_idx), 128'd0);
      chk("rst_sw", 128'(o_switch), 128'd0);
      chk("rst_err", 128'(o_cfg_err), 128'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // identity route, N=1, dwell 2
      wr(3'd0, rt_ident, 8'd2);
      cfg_num_entries = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_en", 128'(o_en), 128'd1);
      chk("t1_cmd", o_cmd, CMD_IDENT);
      chk("t1_sw0", 128'(o_switch), 128'd1);
      chk("t1_busy", 128'(o_busy), 128'd1);
      tick();
      chk("t1_sw1", 128'(o_switch), 128'd0);
      tick();
      chk("t1_sw2", 128'(o_switch), 128'd0);
      tick();
      chk("t1_sw3", 128'(o_switch), 128'd1);
      chk("t1_cmd3", o_cmd, CMD_IDENT);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t1_stopping_en", 128'(o_en), 128'd1);
      tick();
      chk("t1_stopping_busy", 128'(o_busy), 128'd1);
      tick();
      chk("t1_idle_en", 128'(o_en), 128'd0);
      chk("t1_idle_cmd", o_cmd, 128'd0);
      chk("t1_idle_busy", 128'(o_busy), 128'd0);

      // two entries: src15 broadcast (dwell 0), src8->dst0 (dwell 1)
      wr(3'd0, RT_ALL15, 8'd0);
      wr(3'd1, RT_S8D0, 8'd1);
      cfg_num_entries = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_cmd_a", o_cmd, CMD_S15);
      chk("t2_idx_a", 128'(o_entry_idx), 128'd0);
      tick();
      chk("t2_cmd_b", o_cmd, CMD_S8D0);
      chk("t2_idx_b", 128'(o_entry_idx), 128'd1);
      chk("t2_sw_b", 128'(o_switch), 128'd1);
      tick();
      chk("t2_cmd_c", o_cmd, CMD_S8D0);
      chk("t2_sw_c", 128'(o_switch), 128'd0);
      tick();
      chk("t2_cmd_d", o_cmd, CMD_S15);
      chk("t2_idx_d", 128'(o_entry_idx), 128'd0);
      tick();
      chk("t2_idx_e", 128'(o_entry_idx), 128'd1);

      // write lock on the applied entry, write-first on the entry being entered
      cfg_wr_en    = 1'b1;
      cfg_wr_addr  = 3'd1;
      cfg_wr_route = RT_S0D7;
      cfg_wr_dwell = 8'd5;
      tick();
      chk("t4_rej_err", 128'(o_cfg_err), 128'd1);
      cfg_wr_addr  = 3'd0;
      cfg_wr_dwell = 8'd0;
      tick();
      cfg_wr_en = 1'b0;
      chk("t4_acc_err", 128'(o_cfg_err), 128'd0);
      chk("t4_new_cmd", o_cmd, CMD_S0D7);
      chk("t4_new_idx", 128'(o_entry_idx), 128'd0);
      tick();
      chk("t4_kept_cmd", o_cmd, CMD_S8D0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t4_stopping_cmd", o_cmd, CMD_S8D0);
      tick();
      chk("t4_idle_cmd", o_cmd, 128'd0);
      chk("t4_idle_idx", 128'(o_entry_idx), 128'd1);

      // stop one cycle into a dwell-3 entry, start ignored while stopping
      wr(3'd0, rt_ident, 8'd3);
      cfg_num_entries = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      stop  = 1'b1;
      start = 1'b1;
      tick();
      stop = 1'b0;
      chk("t3_hold1", o_cmd, CMD_IDENT);
      chk("t3_busy1", 128'(o_busy), 128'd1);
      tick();
      start = 1'b0;
      chk("t3_hold2", o_cmd, CMD_IDENT);
      tick();
      chk("t3_idle_cmd", o_cmd, 128'd0);
      chk("t3_idle_en", 128'(o_en), 128'd0);
      chk("t3_idle_busy", 128'(o_busy), 128'd0);
      tick();
      chk("t3_still_idle", 128'(o_busy), 128'd0);

      // rejected starts and start+stop
      cfg_num_entries = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_n0_err", 128'(o_cfg_err), 128'd1);
      chk("t5_n0_busy", 128'(o_busy), 128'd0);
      tick();
      chk("t5_err_clr", 128'(o_cfg_err), 128'd0);
      cfg_num_entries = 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_n9_err", 128'(o_cfg_err), 128'd1);
      chk("t5_n9_busy", 128'(o_busy), 128'd0);
      cfg_num_entries = 4'd1;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("t5_ss_err", 128'(o_cfg_err), 128'd0);
      chk("t5_ss_busy", 128'(o_busy), 128'd0);
      chk("t5_ss_en", 128'(o_en), 128'd0);

      // asynchronous reset mid-dwell, table retained
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_run_en", 128'(o_en), 128'd1);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_cmd", o_cmd, 128'd0);
      chk("t6_rst_en", 128'(o_en), 128'd0);
      chk("t6_rst_busy", 128'(o_busy), 128'd0);
      #1 rst = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_replay_cmd", o_cmd, CMD_IDENT);
      chk("t6_replay_en", 128'(o_en), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
